// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: multiply/divide opcodes and sequencer states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Bundle of the multiply/divide unit handshake, operands and results.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic                    start;
    cpu_types_pkg::muldiv_op_t op;
    logic [WIDTH-1:0]        portA;
    logic [WIDTH-1:0]        portB;
    logic                    flush;
    logic                    busy;
    logic                    done;
    logic [WIDTH-1:0]        hi;
    logic [WIDTH-1:0]        lo;
    logic                    div_by_zero;

    modport muldiv (
        input  start, op, portA, portB, flush,
        output busy, done, hi, lo, div_by_zero
    );

    modport tb (
        output start, op, portA, portB, flush,
        input  busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO result registers.
module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q, op_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              dbz_q, dbz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Two's-complement negate at double width; low half doubles as a single-width negate.
    function automatic logic [PW-1:0] negate(input logic [PW-1:0] x);
        return ~x + PW'(1);
    endfunction

    logic             signed_op;
    logic             in_a_neg, in_b_neg;
    logic [WIDTH-1:0] in_a, in_b;
    logic             is_div_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rmd;

    // Next-state, datapath step and registered-output values.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        signed_op = (op == MULT) || (op == DIV);
        in_a_neg  = signed_op & portA[WIDTH-1];
        in_b_neg  = signed_op & portB[WIDTH-1];
        in_a      = in_a_neg ? WIDTH'(negate(PW'(portA))) : portA;
        in_b      = in_b_neg ? WIDTH'(negate(PW'(portB))) : portB;
        is_div_q  = (op_q == DIV) || (op_q == DIVU);
        mul_sum   = '0;
        rem_sh    = '0;
        trial     = '0;
        prod      = '0;
        quo       = '0;
        rmd       = '0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && !flush) begin
                    state_d = CALC;
                    op_d    = op;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = CW'(WIDTH - 1);
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    // Low half holds the multiplier, or the dividend being shifted out.
                    acc_d   = (op == DIV || op == DIVU) ? {WIDTH'(0), in_a} : {WIDTH'(0), in_b};
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_sh = {rem_q, acc_q[WIDTH-1]};
                        trial  = rem_sh - {2'b00, b_q};
                        rem_d  = trial[WIDTH+1] ? rem_sh[WIDTH:0] : trial[WIDTH:0];
                        acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~trial[WIDTH+1]};
                    end else begin
                        mul_sum = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
                        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (is_div_q) begin
                        if (b_q == '0) begin
                            lo_d  = '1;
                            hi_d  = a_neg_q ? WIDTH'(negate(PW'(a_q))) : a_q;
                            dbz_d = 1'b1;
                        end else begin
                            quo  = acc_q[WIDTH-1:0];
                            rmd  = rem_q[WIDTH-1:0];
                            if (a_neg_q ^ b_neg_q) quo = WIDTH'(negate(PW'(quo)));
                            if (a_neg_q) rmd = WIDTH'(negate(PW'(rmd)));
                            lo_d = quo;
                            hi_d = rmd;
                        end
                    end else begin
                        prod = acc_q;
                        if (a_neg_q ^ b_neg_q) prod = negate(prod);
                        hi_d = prod[PW-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= MULT;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that runs beside the single-cycle ALU in the execute stage. It implements MULT, MULTU, DIV and DIVU as radix-2 shift-add and restoring-divide sequences, one bit per cycle. It writes a 2×WIDTH result into HI/LO registers. The unit supports a start/busy/done handshake so the pipeline can stall on it, and a flush input so a squashed instruction can be abandoned.

## Interface
- WIDTH, 32, operand width in bits; any value ≥ 4. Iteration count, HI and LO all scale with it.
- CLK  in  1  rising-edge clock.
- nRST  in  1  reset; asynchronous and active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  muldiv_op_t (2)  MULT, MULTU, DIV, DIVU.
- portA  in  WIDTH  multiplicand or dividend.
- portB  in  WIDTH  multiplier or divisor.
- flush  in  1  synchronous abort of the operation in flight.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse in DONE; HI/LO are valid from this cycle on.
- hi  out  WIDTH  upper product word, or remainder.
- lo  out  WIDTH  lower product word, or quotient.
- div_by_zero  out  1  set with done when a DIV/DIVU had portB = 0; cleared on the next accepted start.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Reset state: IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; internal counter and accumulators cleared.
- Accept (IDLE or DONE, start=1):
  - latch op and the sign flags for signed ops;
  - latch |portA| and |portB| for signed ops, raw values for unsigned ops;
  - counter=WIDTH-1; next state CALC.
- start while busy is ignored; the request is not queued.
- CALC, multiply: shift-add into a 2×WIDTH accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring divide, one quotient bit per cycle, MSB first. The remainder register is WIDTH+1 bits so the trial subtract never loses its borrow.
- CALC lasts exactly WIDTH cycles; on counter==0 go to FIX.
- FIX (1 cycle), result registered into hi/lo:
  - MULT with differing operand signs: 2×WIDTH two's-complement negate of the product.
  - DIV: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Most-negative / -1: quotient wraps to the most-negative value, remainder 0. There is no trap and no special path.
  - Divisor zero: lo = all ones, hi = raw portA as latched, div_by_zero=1. Latency is unchanged.
- DONE (1 cycle): done=1. Next state is IDLE, or CALC if a new start is accepted.
- hi and lo hold their value until the next FIX writes them.
- flush=1 in CALC or FIX: next state IDLE; hi, lo and div_by_zero are unchanged; no done pulse.
- flush in IDLE or DONE has no effect on state. If start and flush are both high in IDLE or DONE, flush wins: the request is not accepted.
- nRST low at any time: immediate return to the reset state, including mid-CALC.

## Timing
- Accept edge = cycle 0.
- busy=1 in cycles 1..WIDTH+1: WIDTH CALC cycles plus one FIX cycle.
- done=1 in cycle WIDTH+2 only (cycle 34 for WIDTH=32). hi, lo and div_by_zero are valid in the same cycle.
- Back-to-back operation: start held in the DONE cycle gives the next done at WIDTH+2 cycles later; the issue interval is WIDTH+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package cpu_types_pkg gets:
  - typedef enum logic [1:0] muldiv_op_t {MULT, MULTU, DIV, DIVU};
  - typedef enum muldiv_state_t {IDLE, CALC, FIX, DONE}.
- New interface muldiv_if:
  - modport muldiv: inputs start, op, portA, portB, flush; outputs busy, done, hi, lo, div_by_zero;
  - modport tb: the mirror of muldiv.
- Counter width: $clog2(WIDTH).
- Single module with no sub-modules. The sign-fix negation is a local function.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly at cycle 34; busy high in cycles 1..33.
- MULT -3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT -3 × -7 → hi=0, lo=0x15.
- Division:
  - DIVU 100 / 7 → lo=14, hi=2.
  - DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done. A following DIVU 9 / 3 clears div_by_zero and returns lo=3, hi=0.
- Flush and restart:
  - complete a MULTU 6 × 7 (lo=42);
  - start MULT 2 × 2 and flush in cycle 10 → busy low in cycle 11, no done, lo stays 42;
  - start again with flush high in the same cycle → not accepted, busy stays low.
- Reset and handshake:
  - assert nRST low in cycle 20 of a DIV → all outputs 0 immediately;
  - after release, start while busy is ignored;
  - start held in the DONE cycle launches the next op with done 34 cycles later.
